// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Streams host instruction words into an instruction memory starting at a
// latched origin address. Each accepted word is written one cycle after its
// handshake, the address wraps modulo 32, and a 16-bit running checksum of the
// accepted words is kept. A load finishes with a one-cycle done pulse. Abort
// returns the block to IDLE without a done pulse.
//
// Optional feature (macro PROGRAM_LOADER_VERIFY_EN): after the load, a VERIFY
// state reads every written word back through the memory's spare read port.
// It sums the read-back data and flags error if that sum differs from the
// checksum.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, abort      begin a load / cancel the load in progress
//   origin, length    first write address, word count (0..32 valid)
//   in_valid, in_data host word handshake (in_ready is combinational)
//   in_ready          loader can accept a word this cycle
//   writeAddress/Data/Enable   registered instruction-memory write port
//   verifyAddress, verifyData  read-back port (used only with the macro)
//   busy, done, error, checksum  status
// ---------------------------------------------------------------------------
module program_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  origin,
    input  logic [5:0]  length,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [4:0]  writeAddress,
    output logic [15:0] writeData,
    output logic        writeEnable,
    output logic [4:0]  verifyAddress,
    input  logic [15:0] verifyData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
`ifdef PROGRAM_LOADER_VERIFY_EN
        S_VERIFY = 2'd3,
`endif
        S_FIN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  origin_q, origin_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  cnt_q, cnt_d;       // words accepted so far
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;
    logic        accept;

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic [5:0]  vcnt_q, vcnt_d;     // read-back index within VERIFY
    logic [15:0] vsum_q, vsum_d;
    logic [15:0] vsum_next;
    assign vsum_next = vsum_q + verifyData;
`endif

    assign in_ready = (state_q == S_LOAD) && (cnt_q < len_q) && !abort;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sum_d    = sum_q;
        err_d    = err_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
        vcnt_d   = vcnt_q;
        vsum_d   = vsum_q;
`endif
        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort here
                if (start) begin
                    origin_d = origin;
                    len_d    = length;
                    cnt_d    = 6'd0;
                    sum_d    = 16'd0;
                    err_d    = 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
                    vcnt_d   = 6'd0;
                    vsum_d   = 16'd0;
`endif
                    if (length == 6'd0) begin
                        state_d = S_FIN;
                    end else if (length > 6'd32) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = origin_q + cnt_q[4:0];
                    wdata_d = in_data;
                    sum_d   = sum_q + in_data;
                    cnt_d   = cnt_q + 6'd1;
                end else if (cnt_q == len_q) begin
                    // All words taken; the last write is on the port this cycle.
`ifdef PROGRAM_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_FIN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    vsum_d = vsum_next;
                    vcnt_d = vcnt_q + 6'd1;
                    if (vcnt_q + 6'd1 == len_q) begin
                        state_d = S_FIN;
                        if (vsum_next != sum_q) err_d = 1'b1;
                    end
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            origin_q <= 5'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            we_q     <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 16'd0;
            sum_q    <= 16'd0;
            err_q    <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            vcnt_q   <= 6'd0;
            vsum_q   <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
`ifdef PROGRAM_LOADER_VERIFY_EN
            vcnt_q   <= vcnt_d;
            vsum_q   <= vsum_d;
`endif
        end
    end

    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign checksum     = sum_q;
    assign error        = err_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);

`ifdef PROGRAM_LOADER_VERIFY_EN
    assign verifyAddress = (state_q == S_VERIFY) ? (origin_q + vcnt_q[4:0]) : 5'd0;
`else
    // Read-back port is not used in this build.
    logic unused_verify_data;
    assign unused_verify_data = ^verifyData;
    assign verifyAddress      = 5'd0;
`endif

endmodule
